// File: rtl/pipe_stage_reg.sv
`timescale 1ns/1ps
// Elastic pipeline stage register: valid/ready handshake, flush, bubble masking
// of control bits, and an optional skid entry that keeps in_ready registered.
module pipe_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 133,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    localparam bit HAS_SKID = (SKID != 0);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;

    logic take_in;
    logic take_out;

    assign out_valid = (state_reg != EMPTY);

    // With a skid entry, in_ready never looks at out_ready.
    generate
        if (HAS_SKID) begin : g_ready_skid
            assign in_ready = (state_reg != SKID_FULL) & clrn & ~flush;
        end else begin : g_ready_single
            assign in_ready = (~out_valid | out_ready) & clrn & ~flush;
        end
    endgenerate

    assign take_in  = in_valid & in_ready;
    assign take_out = out_valid & out_ready;

    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (take_in) begin
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                        state_next     = FULL;
                    end
                end
                FULL: begin
                    if (take_in && take_out) begin
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end else if (take_out) begin
                        state_next = EMPTY;
                    end else if (take_in && HAS_SKID) begin
                        skid_ctrl_next = in_ctrl;
                        skid_data_next = in_data;
                        state_next     = SKID_FULL;
                    end
                end
                SKID_FULL: begin
                    if (take_out) begin
                        main_ctrl_next = skid_ctrl_reg;
                        main_data_next = skid_data_reg;
                        state_next     = FULL;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
        end
    end

    always_comb begin
        count = 2'd0;
        case (state_reg)
            FULL:      count = 2'd1;
            SKID_FULL: count = 2'd2;
            default:   count = 2'd0;
        endcase
    end

    // An empty stage must look like a bubble: no register or memory write.
    generate
        for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            assign out_ctrl[gi] = main_ctrl_reg[gi] & out_valid;
        end
    endgenerate

    assign out_data = main_data_reg;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register for the 5-stage CPU, a drop-in replacement for the fixed ID/EXE, EXE/MEM and MEM/WB latches. It carries a control field and a data payload with a valid/ready handshake. It supports back-pressure (stall), synchronous flush (branch/jump kill) and bubble insertion. An optional skid entry gives full throughput with a registered `in_ready`.

## Interface
Parameters:
- `CTRL_W`, default 16: control bits (wreg, m2reg, wmem, aluc, selects, branch flags…). These are forced to 0 whenever the stage holds no valid instruction.
- `DATA_W`, default 133: payload bits (operands, imm, rn, bpc…). These are not masked.
- `SKID`, default 1: 1 adds a second (skid) entry and makes `in_ready` registered; 0 gives a single entry with combinational `in_ready`.

Ports:
- `clk` in 1: rising-edge clock.
- `clrn` in 1: synchronous, active-low reset.
- `flush` in 1: kills every held and incoming entry at the next edge.
- `in_valid` in 1: upstream holds an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_ctrl` in CTRL_W: control field.
- `in_data` in DATA_W: payload.
- `out_valid` out 1: stage presents an instruction.
- `out_ready` in 1: downstream accepts this cycle (0 = stall).
- `out_ctrl` out CTRL_W: registered control field, ANDed with `out_valid`.
- `out_data` out DATA_W: registered payload.
- `count` out 2: occupancy, 0..2 (max 1 when SKID=0).

## Operation
- Transfer in = `in_valid & in_ready`. Transfer out = `out_valid & out_ready`.
- Storage: main entry (drives outputs) and, when SKID=1, a skid entry. Each entry holds {ctrl, data}.
- States: EMPTY (count 0), FULL (count 1), SKID_FULL (count 2, only when SKID=1).
- `in_ready`:
  - SKID=1: `in_ready` = (state != SKID_FULL) & clrn & ~flush.
  - SKID=0: `in_ready` = (~out_valid | out_ready) & clrn & ~flush.
- Transitions when no flush:
  - EMPTY: transfer in → main ← in, go to FULL.
  - FULL, both transfers → main ← in, stay FULL.
  - FULL, transfer out only → go to EMPTY.
  - FULL, transfer in only → skid ← in, go to SKID_FULL. With SKID=0 this case cannot occur.
  - FULL, neither → hold.
  - SKID_FULL, `out_ready` → main ← skid, go to FULL. There is no transfer in, because `in_ready` is 0.
  - SKID_FULL, `~out_ready` → hold.
- `flush`: next state is EMPTY, skid is discarded, and `in_ready` is 0 during the flush cycle, so nothing is accepted. The `out_valid` entry may still be taken downstream in the flush cycle; the handshake is honoured, and the entry is then removed.
- Bubble: whenever `out_valid` = 0, `out_ctrl` = 0. This means no register write and no memory write. `out_data` keeps the last loaded value.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.

## Timing
- Reset (`clrn` = 0 at a rising edge): state EMPTY, main and skid ← 0, `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0, `count` = 0. `in_ready` = 0 combinationally while `clrn` = 0.
- Reset takes priority over `flush`, which takes priority over transfers.
- Reset mid-operation discards both entries with no partial update.
- Latency: 1 cycle, in → out, when not stalled.
- Throughput: 1 per cycle under continuous `out_ready`, for both SKID values.
- SKID=1: `in_ready` depends only on the state, `clrn` and `flush`. It has no combinational path from `out_ready`.
- Simultaneous `in_valid` and `out_ready` in FULL gives a one-cycle replacement with `count` unchanged.
- `count` is updated on the same edge as the state.

## Test plan
- Reset and fill: hold `clrn` = 0 for 2 cycles with `in_valid` = 1 and `in_ctrl` = 16'hFFFF → `out_valid` = 0, `out_ctrl` = 0, `in_ready` = 0. Release and stream ids 1..8 with `out_ready` = 1 → outputs 1..8 on consecutive cycles, each 1 cycle late.
- Stall with skid (SKID=1): stream 1..4 and drop `out_ready` for 3 cycles while output shows 2. Required: `count` goes to 2, `in_ready` = 0, output holds 2. Raise `out_ready` → 2, 3, 4 in order, none lost or duplicated.
- Flush: with SKID_FULL holding {5, 6}, pulse `flush` together with `in_valid` carrying 7. Required: `in_ready` = 0 that cycle, and next cycle `out_valid` = 0, `out_ctrl` = 0, `count` = 0. Then 7 is re-sent and accepted.
- Bubble masking: insert `in_valid` = 0 gaps between ids 10 and 11 with `in_ctrl` = 16'h00FF. Required: `out_ctrl` = 0 on gap cycles and `out_data` equal to 10's payload.
- SKID=0 build: repeat the stall scenario. Required: `count` ≤ 1, and `in_ready` follows `out_ready` in the same cycle while FULL.
- Random handshake: 10k cycles of random `in_valid`/`out_ready`/`flush` (flush 2 %) against a scoreboard. Required: FIFO order, no accepted-then-lost entry except by flush, and throughput = 1 when both sides are always ready.
